pipelined_csel_adder: RTL and testbench

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

---
 rtl/pipelined_csel_adder.sv | 139 +++++++++++++
 tb/tb_pipelined_csel_adder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// Carry-select adder split into pipeline stages of PIPE_SEGS segments, with valid/ready handshake.
// Optional subtract mode under `ifdef CSEL_ADDER_SUB_EN (adds input sub: a + ~b + 1, ci ignored).
module pipelined_csel_adder #(
  parameter int WIDTH     = 32,
  parameter int SEG_W     = 4,
  parameter int PIPE_SEGS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef CSEL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int NSEG = WIDTH / SEG_W;
  localparam int NSTG = (NSEG + PIPE_SEGS - 1) / PIPE_SEGS;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

`ifdef CSEL_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | ci;
`else
  assign b_eff = b;
  assign c_eff = ci;
`endif

  // Flattened lookahead: each carry is a sum of generate terms, not a ripple chain.
  function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] x, y, input logic cin);
    logic [SEG_W-1:0] gen, prp;
    logic [SEG_W:0]   c;
    logic             t;
    gen  = x & y;
    prp  = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG_W; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) t = t & prp[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = gen[j];
        for (int m = j + 1; m <= i; m++) t = t & prp[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[SEG_W], prp ^ c[SEG_W-1:0]};
  endfunction

  function automatic logic [SEG_W:0] csel_seg(input logic [SEG_W-1:0] x, y, input logic cin);
    logic [SEG_W:0] r0, r1;
    r0 = {1'b0, x} + {1'b0, y};
    r1 = {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, 1'b1};
    return {r0[SEG_W] | (cin & r1[SEG_W]), cin ? r1[SEG_W-1:0] : r0[SEG_W-1:0]};
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * PIPE_SEGS;
    localparam int HI = ((k + 1) * PIPE_SEGS < NSEG) ? (k + 1) * PIPE_SEGS : NSEG;
    localparam int RW = WIDTH - LO * SEG_W;  // operand bits still unresolved entering this stage
    localparam int NW = (HI - LO) * SEG_W;   // sum bits resolved in this stage

    logic [RW-1:0]       a_i, b_i;
    logic                c_i, v_i;
    logic [NW-1:0]       ns;
    logic [SEG_W:0]      r;
    logic                c_o;
    logic [HI*SEG_W-1:0] s_d, s_q;
    logic                c_q, v_q;

    if (k == 0) begin : g_src
      assign a_i = a;
      assign b_i = b_eff;
      assign c_i = c_eff;
      assign v_i = in_valid;
      assign s_d = ns;
    end else begin : g_src
      assign a_i = g_stg[k-1].g_op.a_q;
      assign b_i = g_stg[k-1].g_op.b_q;
      assign c_i = g_stg[k-1].c_q;
      assign v_i = g_stg[k-1].v_q;
      assign s_d = {ns, g_stg[k-1].s_q};
    end

    always_comb begin
      ns  = '0;
      r   = '0;
      c_o = c_i;
      for (int g = LO; g < HI; g++) begin
        if (g == 0) r = cla_seg(a_i[(g-LO)*SEG_W +: SEG_W], b_i[(g-LO)*SEG_W +: SEG_W], c_o);
        else        r = csel_seg(a_i[(g-LO)*SEG_W +: SEG_W], b_i[(g-LO)*SEG_W +: SEG_W], c_o);
        ns[(g-LO)*SEG_W +: SEG_W] = r[SEG_W-1:0];
        c_o = r[SEG_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_i;
        c_q <= c_o;
        s_q <= s_d;
      end
    end

    // Skew registers: only the operand slices later stages still need.
    if (k < NSTG - 1) begin : g_op
      logic [RW-NW-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_i[RW-1:NW];
          b_q <= b_i[RW-1:NW];
        end
      end
    end
  end

  assign s         = g_stg[NSTG-1].s_q;
  assign co        = g_stg[NSTG-1].c_q;
  assign out_valid = g_stg[NSTG-1].v_q;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder: random and directed beats against an arithmetic model.
module tb_pipelined_csel_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        ci;
`ifdef CSEL_ADDER_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        co;

  pipelined_csel_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
`ifdef CSEL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] exp;
    int          cyc;
    int          stl;
  } ent_t;

  ent_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  bit          done = 0;
  logic [32:0] hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain wide-integer arithmetic; subtraction as a compare plus difference.
  function automatic logic [32:0] model(input logic [31:0] x, y, input logic c, input logic sb);
    longint t;
    if (sb) return {x >= y, x - y};
    t = longint'(x) + longint'(y) + longint'(c);
    return t[32:0];
  endfunction

  initial begin : monitor
    ent_t e;
    logic sb;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
        chk("in_ready_in_reset", in_ready, 1);
        chk("out_valid_in_reset", out_valid, 0);
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_sum", {co, s}, hold);
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got s=%h co=%b, required no output", s, co);
          end else begin
            e = q.pop_front();
            chk("sum", {co, s}, e.exp);
            chk("latency", cyc - e.cyc, 4 + stall_cnt - e.stl);
          end
        end
        if (in_valid && in_ready) begin
          sb = 1'b0;
`ifdef CSEL_ADDER_SUB_EN
          sb = sub;
`endif
          e.exp = model(a, b, ci, sb);
          e.cyc = cyc;
          e.stl = stall_cnt;
          q.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) begin
          stall_cnt++;
          hold = {co, s};
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tci);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    ci = tci;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send_rand();
    send($urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  initial begin : stim
    int n0, s0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    send(32'h0000_0001, 32'h0000_0002, 1'b0);
    idle(6);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    idle(6);

    n0 = n_out;
    for (int i = 0; i < 100; i++) send_rand();
    drain();
    chk("stream_count", n_out - n0, 100);

    n0 = n_out;
    s0 = stall_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_cycles", stall_cnt - s0, 5);
    chk("bp_count", n_out - n0, 10);

    n0 = n_out;
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand();
          idle($urandom_range(0, 2));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", n_out - n0, 40);

    for (int i = 0; i < 4; i++) send_rand();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    q.delete();
    idle(2);
    rst_n = 1'b1;
    n0 = n_out;
    idle(8);
    chk("no_stale_results", n_out - n0, 0);
    chk("no_stale_valid", out_valid, 0);

`ifdef CSEL_ADDER_SUB_EN
    sub = 1'b1;
    send(32'd5, 32'd7, 1'b0);
    send(32'd7, 32'd5, 1'b1);
    for (int i = 0; i < 10; i++) send_rand();
    drain();
    sub = 1'b0;
`endif

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
